// File: rtl/req_enc_pkg.sv
// Shared constants, FSM state type and helpers for the 4-to-2 request encoder.
// Optional lost-request detection in the top is enabled by REQ_ENC_DROP_FLAG_EN.
package req_enc_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] idx2oh(
    input logic [IDX_W-1:0] idx
  );
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/req_encoder_4x2_rr_pick.sv
// Round-robin picker: first set bit of cand at or above ptr, wrapping.
// Rotates cand down by ptr, priority-encodes, then rotates the index back.
module rr_pick
  import req_enc_pkg::*;
(
  input  logic [N_REQ-1:0] cand,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] pick
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] enc;

  always_comb begin
    rot   = N_REQ'({cand, cand} >> ptr);
    found = |rot;
    enc   = '0;
    // Descending scan leaves the lowest set bit in enc.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) enc = IDX_W'(i);
    end
    pick = enc + ptr;
  end

endmodule

// File: rtl/req_encoder_4x2.sv
// Sticky request collector serving one index per valid/ready transfer.
// Build with REQ_ENC_DROP_FLAG_EN to flag requests merged into pending.
module req_encoder_4x2
  import req_enc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [N_REQ-1:0] out_onehot,
  output logic             drop_err
);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_REQ-1:0] onehot_q, onehot_d;

  logic [N_REQ-1:0] cand;
  logic             found;
  logic [IDX_W-1:0] pick;
  logic             take;

  assign cand = pending_q | req_in;

  rr_pick u_pick (
    .cand  (cand),
    .ptr   (ptr_q),
    .found (found),
    .pick  (pick)
  );

  // Idle always looks for work; HOLD only moves on a transfer.
  assign take = (state_q == IDLE) || out_ready;

  always_comb begin
    state_d   = state_q;
    pending_d = cand;
    ptr_d     = ptr_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    onehot_d  = onehot_q;
    if (take) begin
      if (found) begin
        state_d   = HOLD;
        valid_d   = 1'b1;
        idx_d     = pick;
        onehot_d  = idx2oh(pick);
        pending_d = cand & ~idx2oh(pick);
        ptr_d     = pick + IDX_W'(1);
      end else begin
        state_d  = IDLE;
        valid_d  = 1'b0;
        onehot_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      ptr_q     <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      onehot_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      onehot_q  <= onehot_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_idx    = idx_q;
  assign out_onehot = onehot_q;

`ifdef REQ_ENC_DROP_FLAG_EN
  logic drop_q, drop_d;

  always_comb begin
    drop_d = drop_q | (|(req_in & pending_q));
  end

  always_ff @(posedge clk) begin
    if (rst) drop_q <= 1'b0;
    else     drop_q <= drop_d;
  end

  assign drop_err = drop_q;
`else
  assign drop_err = 1'b0;
`endif

endmodule
